// File: rtl/voter_record_ram_pkg.sv
// voter_record_ram_pkg: shared defaults and FSM state encoding for the voter record RAM.
package voter_record_ram_pkg;
    localparam int WORD_SIZE_DEF    = 5;
    localparam int ADDRESS_SIZE_DEF = 4;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        RESP     = 3'd2,
        WAIT_LOW = 3'd3,
        CLEAR    = 3'd4
    } state_t;
endpackage

// File: rtl/voter_record_ram_flag_mem.sv
// voter_flag_mem: {voted flag, ID} array with one sync write port and two sync read ports.
module voter_flag_mem #(
    parameter int WORD_SIZE    = 5,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic [ADDRESS_SIZE-1:0] i_waddr,
    input  logic [WORD_SIZE:0]      i_wdata,
    input  logic                    i_lk_en,
    input  logic [ADDRESS_SIZE-1:0] i_lk_addr,
    output logic                    o_lk_flag,
    input  logic                    i_rd_en,
    input  logic [ADDRESS_SIZE-1:0] i_rd_addr,
    output logic [WORD_SIZE:0]      o_rd_data
);
    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    logic [WORD_SIZE:0] r_mem [DEPTH];
    // Reads sample the array before this edge's write, so a colliding read returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            o_lk_flag <= 1'b0;
            o_rd_data <= '0;
        end else begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            if (i_lk_en) o_lk_flag <= r_mem[i_lk_addr][WORD_SIZE];
            if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
        end
    end
endmodule

// File: rtl/voter_record_ram.sv
// voter_record_ram: one-vote-per-voter record store with duplicate detection and clear sweep.
// Define VOTE_COUNT_EN to add the saturating vote_count output.
module voter_record_ram
    import voter_record_ram_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic [ADDRESS_SIZE-1:0] valid_voter_address,
    input  logic [WORD_SIZE-1:0]    valid_voter,
    input  logic                    clear_req,
    input  logic                    read_enable,
    input  logic [ADDRESS_SIZE-1:0] read_address,
    output logic                    vote_allowed,
    output logic                    duplicate,
    output logic                    busy,
    output logic                    clear_done,
    output logic [WORD_SIZE:0]      read_data
`ifdef VOTE_COUNT_EN
    ,
    output logic [ADDRESS_SIZE:0]   vote_count
`endif
);
    state_t                  r_state, w_next;
    logic [ADDRESS_SIZE-1:0] r_addr, r_sweep, w_waddr;
    logic [WORD_SIZE-1:0]    r_id;
    logic                    r_pend, w_flag, w_we, w_clear;
    logic [WORD_SIZE:0]      w_wdata;

    assign w_clear      = r_state == CLEAR;
    assign vote_allowed = r_state == RESP && !w_flag;
    assign duplicate    = r_state == RESP && w_flag;
    assign busy         = r_state != IDLE;
    assign clear_done   = w_clear && r_sweep == '1;
    assign w_we         = vote_allowed || w_clear;
    assign w_waddr      = w_clear ? r_sweep : r_addr;
    assign w_wdata      = w_clear ? '0 : {1'b1, r_id};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = (clear_req || r_pend) ? CLEAR : write ? LOOKUP : IDLE;
            LOOKUP:   w_next = RESP;
            RESP:     w_next = WAIT_LOW;
            WAIT_LOW: w_next = write ? WAIT_LOW : IDLE;
            CLEAR:    w_next = (r_sweep == '1) ? IDLE : CLEAR;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_id    <= '0;
            r_pend  <= 1'b0;
            r_sweep <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == LOOKUP) begin
                r_addr <= valid_voter_address;
                r_id   <= valid_voter;
            end
            // IDLE always services a pending clear, so it is dropped there; CLEAR ignores new requests.
            r_pend  <= (r_state == IDLE) ? 1'b0 : (!w_clear && clear_req) ? 1'b1 : r_pend;
            r_sweep <= w_clear ? r_sweep + 1'b1 : r_sweep;
        end
    end

    voter_flag_mem #(.WORD_SIZE(WORD_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_lk_en   (r_state == LOOKUP),
        .i_lk_addr (r_addr),
        .o_lk_flag (w_flag),
        .i_rd_en   (read_enable),
        .i_rd_addr (read_address),
        .o_rd_data (read_data)
    );

`ifdef VOTE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vote_count <= '0;
        else if (r_state == IDLE && w_next == CLEAR) vote_count <= '0;
        else if (vote_allowed && !vote_count[ADDRESS_SIZE]) vote_count <= vote_count + 1'b1;
    end
`endif
endmodule
